// File: rtl/tx_arb.sv
// tx_arb: shares one character transmitter between NB_REQ requesters.
//
// A requester holds i_req and its slice of i_data until it sees its o_ack.
// When the transmitter reports empty (i_mty=1), one requester is granted and
// its character is written with a single-cycle o_we strobe. After a write the
// arbiter waits for i_mty to fall before it will grant again. This protects
// against writing twice while the empty flag is stale.
//
// Winner selection is round-robin starting at ptr. The last grantee can keep
// ownership through i_lock, but only for up to MAX_BURST grants in a row.
//
// Ports
//   i_clk, i_nrst : clock (rising edge), asynchronous active-low reset
//   i_req         : per-requester character pending (level)
//   i_lock        : per-requester request to keep ownership for the next char
//   i_data        : requester k's character in [k*WIDTH_DATA +: WIDTH_DATA]
//   i_mty         : transmitter empty flag
//   o_we, o_data  : registered write strobe and character to the transmitter
//   o_ack         : registered one-hot pulse, character of that requester taken
//   o_gnt         : registered one-hot index of the last grantee (0 before any)
//   o_busy        : high while the arbiter is not in READY
//
// state    | meaning
// ---------+---------------------------------------------------------------
// READY    | idle; grants when i_mty=1 and an eligible request is pending
// LAUNCH   | write strobe and ack are on the outputs for this one cycle
// WAIT_LOW | waiting for the transmitter to take the character (i_mty=0)
module tx_arb #(
   parameter int WIDTH_DATA = 8,
   parameter int NB_REQ     = 4,
   parameter int MAX_BURST  = 16
) (
   input  logic                         i_clk,
   input  logic                         i_nrst,
   input  logic [NB_REQ-1:0]            i_req,
   input  logic [NB_REQ-1:0]            i_lock,
   input  logic [NB_REQ*WIDTH_DATA-1:0] i_data,
   input  logic                         i_mty,
   output logic                         o_we,
   output logic [WIDTH_DATA-1:0]        o_data,
   output logic [NB_REQ-1:0]            o_ack,
   output logic [NB_REQ-1:0]            o_gnt,
   output logic                         o_busy
);

   localparam int PW = $clog2(NB_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {
      READY    = 2'd0,
      LAUNCH   = 2'd1,
      WAIT_LOW = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         ptr_q, ptr_d;
   logic [PW-1:0]         gidx_q, gidx_d;
   logic [BW-1:0]         burst_q, burst_d;
   logic                  we_q, we_d;
   logic [WIDTH_DATA-1:0] data_q, data_d;
   logic [NB_REQ-1:0]     ack_q, ack_d;
   logic [NB_REQ-1:0]     gnt_q, gnt_d;
   logic                  busy_q, busy_d;

   logic                  lock_hit;
   logic                  rr_found;
   logic [PW-1:0]         rr_idx;
   logic [PW-1:0]         win;
   logic [WIDTH_DATA-1:0] win_data;

   // gidx_q is meaningful only after the first grant, so an empty o_gnt
   // blocks the lock path.
   assign lock_hit = (|gnt_q) && i_lock[gidx_q] && i_req[gidx_q]
                     && (burst_q < BW'(MAX_BURST));

   // Round-robin search: check ptr first, then ptr+1, and so on, wrapping at NB_REQ.
   always_comb begin
      int k;
      k        = 0;
      rr_found = 1'b0;
      rr_idx   = '0;
      for (int i = 0; i < NB_REQ; i++) begin
         k = (int'(ptr_q) + i) % NB_REQ;
         if (!rr_found && i_req[PW'(k)]) begin
            rr_found = 1'b1;
            rr_idx   = PW'(k);
         end
      end
   end

   assign win = lock_hit ? gidx_q : rr_idx;

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NB_REQ; i++) begin
         if (win == PW'(i)) begin
            win_data = i_data[i*WIDTH_DATA +: WIDTH_DATA];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gidx_d  = gidx_q;
      burst_d = burst_q;
      we_d    = 1'b0;
      ack_d   = '0;
      data_d  = data_q;
      gnt_d   = gnt_q;
      case (state_q)
         READY: begin
            if (i_mty && (lock_hit || rr_found)) begin
               we_d    = 1'b1;
               data_d  = win_data;
               ack_d   = NB_REQ'(1) << win;
               gnt_d   = NB_REQ'(1) << win;
               gidx_d  = win;
               ptr_d   = (win == PW'(NB_REQ - 1)) ? '0 : win + PW'(1);
               burst_d = lock_hit ? burst_q + BW'(1) : BW'(1);
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            state_d = WAIT_LOW;
         end
         WAIT_LOW: begin
            // A high i_mty here is stale. Only the low level from the
            // transmitter re-arms the arbiter.
            if (!i_mty) begin
               state_d = READY;
            end
         end
         default: begin
            state_d = READY;
         end
      endcase
      busy_d = (state_d != READY);
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q <= READY;
         ptr_q   <= '0;
         gidx_q  <= '0;
         burst_q <= '0;
         we_q    <= 1'b0;
         data_q  <= '0;
         ack_q   <= '0;
         gnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         burst_q <= burst_d;
         we_q    <= we_d;
         data_q  <= data_d;
         ack_q   <= ack_d;
         gnt_q   <= gnt_d;
         busy_q  <= busy_d;
      end
   end

   assign o_we   = we_q;
   assign o_data = data_q;
   assign o_ack  = ack_q;
   assign o_gnt  = gnt_q;
   assign o_busy = busy_q;

endmodule

// File: doc/tx_arb.md
TX_ARB -- requirements
Module: tx_arb

Interface
REQ-001 Parameter WIDTH_DATA, default 8: width of one character.
REQ-002 Parameter NB_REQ, default 4: number of requesters sharing one transmitter; NB_REQ >= 2.
REQ-003 Parameter MAX_BURST, default 16: maximum consecutive locked grants to one requester; MAX_BURST >= 1.
REQ-004 i_clk  in  1  single clock, rising-edge active.
REQ-005 i_nrst  in  1  reset, asynchronous, active-low.
REQ-006 i_req  in  NB_REQ  per-requester "character pending", level.
REQ-007 i_lock  in  NB_REQ  per-requester "keep ownership for next character".
REQ-008 i_data  in  NB_REQ*WIDTH_DATA  requester k's character in bits [k*WIDTH_DATA +: WIDTH_DATA].
REQ-009 i_mty  in  1  transmitter empty flag; 1 = transmitter can accept a character.
REQ-010 o_we  out  1  registered one-cycle write strobe to the transmitter.
REQ-011 o_data  out  WIDTH_DATA  registered character to the transmitter; valid while o_we=1.
REQ-012 o_ack  out  NB_REQ  registered one-hot pulse; the character of that requester was taken.
REQ-013 o_gnt  out  NB_REQ  registered one-hot index of the last granted requester; 0 before the first grant.
REQ-014 o_busy  out  1  high while state is not READY.

Function
REQ-015 FSM states: READY, LAUNCH, WAIT_LOW.
REQ-016 READY: when i_mty=1 and an eligible request exists, select a winner; on that edge set o_we=1, o_data=winner data, o_ack=winner one-hot, o_gnt=winner one-hot; go to LAUNCH.
REQ-017 READY with i_mty=0 or no request: stay; o_we=0, o_ack=0.
REQ-018 LAUNCH lasts exactly one cycle; o_we and o_ack are 1 during it and 0 on exit; next state is WAIT_LOW.
REQ-019 WAIT_LOW: stay until i_mty=0 is sampled, then go to READY; i_mty=1 is ignored here so a stale empty flag never causes a second write.
REQ-020 Latency: o_we rises one cycle after the READY cycle where i_mty=1 and i_req is asserted.
REQ-021 Round-robin pointer ptr, range 0..NB_REQ-1, resets to 0; after each grant ptr = (winner+1) mod NB_REQ.
REQ-022 Normal selection: the first k with i_req[k]=1, searching ptr, ptr+1, ... with wrap-around past NB_REQ-1 to 0.
REQ-023 Lock: in READY, let g be the o_gnt index. If i_lock[g]=1, i_req[g]=1 and burst count < MAX_BURST, g wins regardless of ptr.
REQ-024 Burst count resets to 0; it is set to 1 on a normal-selection grant and incremented on a lock grant.
REQ-025 When burst count = MAX_BURST, lock is ignored and normal selection applies; if no other requester is pending, g wins again with burst count = 1.
REQ-026 A requester holds i_req and i_data stable until its o_ack.
REQ-027 Deasserting i_req before o_ack withdraws the request; no write occurs for it.
REQ-028 Request or lock changes outside READY have no effect until READY.
REQ-029 Data is sampled only on the READY edge that launches the write; later i_data changes do not alter o_data.

Reset
REQ-030 Asynchronous i_nrst=0 forces: state=READY, o_we=0, o_data=0, o_ack=0, o_gnt=0, ptr=0, burst count=0, o_busy=0.
REQ-031 Reset during LAUNCH or WAIT_LOW aborts immediately, with no further strobe, and leaves the block in the state of REQ-030.
REQ-032 After reset release, the first grant uses normal selection starting at index 0.

Verification
REQ-033 Single request: i_mty=1, i_req=4'b0100, data2=8'hA5 -> next cycle o_we=1, o_data=8'hA5, o_ack=4'b0100, o_gnt=4'b0100 for one cycle.
REQ-034 Round-robin: i_req=4'b1111 held, i_lock=0; tx model drops i_mty for 10 cycles after each write -> grant order 0,1,2,3,0.
REQ-035 Lock and burst cap: MAX_BURST=3, i_req=4'b0011, i_lock=4'b0001, first grant to 0 -> order 0,0,0,1,0,0,0,1.
REQ-036 Stale empty flag: i_mty held at 1 for 3 cycles after o_we, then 0 for 5 cycles, then 1 -> exactly one o_we until i_mty has fallen and risen again.
REQ-037 Withdraw and wrap: ptr=3, i_req=4'b1001; requester 3 withdraws while i_mty=0; i_mty then rises -> requester 0 is granted and ptr becomes 1.
REQ-038 Reset mid-operation: assert i_nrst=0 during WAIT_LOW -> all outputs 0 immediately; after release with i_req=4'b0110 and i_mty=1 -> requester 1 is granted first.
